// File: rtl/vid_timing_gen_if.sv
// Raster output bundle carried from the timing generator to its sink.
interface vid_timing_gen_if;
    logic        hs_o;
    logic        vs_o;
    logic        de_o;
    logic [23:0] data_o;
    logic        frame_start_o;
    logic [7:0]  frame_cnt_o;

    modport master (output hs_o, vs_o, de_o, data_o, frame_start_o, frame_cnt_o);
    modport slave  (input  hs_o, vs_o, de_o, data_o, frame_start_o, frame_cnt_o);
endinterface

// File: rtl/vid_timing_gen.sv
// Raster timing generator with block-aligned test patterns.
// Outputs are registered decodes of the previous cycle's (h,v) position.
module vid_timing_gen #(
    parameter int unsigned H_WIDTH  = 1920,
    parameter int unsigned H_START  = 2008,
    parameter int unsigned H_SYNC   = 44,
    parameter int unsigned H_TOTAL  = 2200,
    parameter int unsigned V_HEIGHT = 1080,
    parameter int unsigned V_START  = 1084,
    parameter int unsigned V_SYNC   = 5,
    parameter int unsigned V_TOTAL  = 1125,
    parameter int unsigned KH       = 30,
    parameter int unsigned KV       = 30
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    input  logic [1:0]         pattern_i,
    input  logic [23:0]        color_i,
    vid_timing_gen_if.master   vid
);

    localparam int unsigned HCW    = (H_TOTAL > 2) ? $clog2(H_TOTAL) : 1;
    localparam int unsigned VCW    = (V_TOTAL > 2) ? $clog2(V_TOTAL) : 1;
    localparam int unsigned HBW    = (KH > 2) ? $clog2(KH) : 1;
    localparam int unsigned VBW    = (KV > 2) ? $clog2(KV) : 1;
    localparam int unsigned H_BLKS = (H_WIDTH + KH - 1) / KH;
    localparam int unsigned V_BLKS = (V_HEIGHT + KV - 1) / KV;
    localparam int unsigned HKW    = (H_BLKS > 1) ? $clog2(H_BLKS + 1) : 1;
    localparam int unsigned VKW    = (V_BLKS > 1) ? $clog2(V_BLKS + 1) : 1;

    localparam logic [HCW-1:0] H_LAST   = HCW'(H_TOTAL - 1);
    localparam logic [VCW-1:0] V_LAST   = VCW'(V_TOTAL - 1);
    localparam logic [HCW-1:0] H_ACT    = HCW'(H_WIDTH);
    localparam logic [VCW-1:0] V_ACT    = VCW'(V_HEIGHT);
    localparam logic [HCW-1:0] HS_FIRST = HCW'(H_START);
    localparam logic [HCW-1:0] HS_LAST  = HCW'(H_START + H_SYNC - 1);
    localparam logic [VCW-1:0] VS_FIRST = VCW'(V_START);
    localparam logic [VCW-1:0] VS_LAST  = VCW'(V_START + V_SYNC - 1);
    localparam logic [HBW-1:0] HB_LAST  = HBW'(KH - 1);
    localparam logic [VBW-1:0] VB_LAST  = VBW'(KV - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e         state_q, state_d;
    logic [HCW-1:0] h_q, h_d;
    logic [VCW-1:0] v_q, v_d;
    logic [HBW-1:0] hb_q, hb_d;
    logic [VBW-1:0] vb_q, vb_d;
    logic [HKW-1:0] hblk_q, hblk_d;
    logic [VKW-1:0] vblk_q, vblk_d;
    logic [1:0]     pat_q, pat_d;
    logic [23:0]    col_q, col_d;
    logic [7:0]     fcnt_q, fcnt_d;

    logic           hs_q, hs_d;
    logic           vs_q, vs_d;
    logic           de_q, de_d;
    logic           fs_q, fs_d;
    logic [23:0]    data_q, data_d;

    logic           h_end_c;
    logic           v_end_c;
    logic           run_c;
    logic [23:0]    checker_c;

    assign h_end_c = (h_q == H_LAST);
    assign v_end_c = (v_q == V_LAST);
    assign run_c   = (state_q == S_RUN);

    // Sequencing: position, block counters, frame-start latch and frame count
    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        v_d     = v_q;
        hb_d    = hb_q;
        vb_d    = vb_q;
        hblk_d  = hblk_q;
        vblk_d  = vblk_q;
        pat_d   = pat_q;
        col_d   = col_q;
        fcnt_d  = fcnt_q;

        case (state_q)
            S_IDLE: begin
                h_d    = '0;
                v_d    = '0;
                hb_d   = '0;
                vb_d   = '0;
                hblk_d = '0;
                vblk_d = '0;
                if (en_i) begin
                    state_d = S_RUN;
                    pat_d   = pattern_i;
                    col_d   = color_i;
                end
            end
            S_RUN: begin
                if (h_end_c) begin
                    h_d    = '0;
                    hb_d   = '0;
                    hblk_d = '0;
                    if (v_end_c) begin
                        v_d    = '0;
                        vb_d   = '0;
                        vblk_d = '0;
                        fcnt_d = fcnt_q + 8'd1;
                        if (en_i) begin
                            pat_d = pattern_i;
                            col_d = color_i;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        v_d = v_q + VCW'(1);
                        if (v_q < V_ACT) begin
                            if (vb_q == VB_LAST) begin
                                vb_d   = '0;
                                vblk_d = vblk_q + VKW'(1);
                            end else begin
                                vb_d = vb_q + VBW'(1);
                            end
                        end
                    end
                end else begin
                    h_d = h_q + HCW'(1);
                    if (h_q < H_ACT) begin
                        if (hb_q == HB_LAST) begin
                            hb_d   = '0;
                            hblk_d = hblk_q + HKW'(1);
                        end else begin
                            hb_d = hb_q + HBW'(1);
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode of the current position; registered below
    always_comb begin
        checker_c = (hblk_q[0] ^ vblk_q[0]) ? 24'h000000 : 24'hFFFFFF;
        de_d      = run_c && (h_q < H_ACT) && (v_q < V_ACT);
        hs_d      = run_c && (h_q >= HS_FIRST) && (h_q <= HS_LAST);
        vs_d      = run_c && (v_q >= VS_FIRST) && (v_q <= VS_LAST);
        fs_d      = run_c && (h_q == '0) && (v_q == '0);
        data_d    = '0;
        if (de_d) begin
            case (pat_q)
                2'd0:    data_d = col_q;
                2'd1:    data_d = checker_c;
                2'd2:    data_d = {3{8'(h_q)}};
                default: data_d = checker_c ^ {24{fcnt_q[0]}};
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            h_q     <= '0;
            v_q     <= '0;
            hb_q    <= '0;
            vb_q    <= '0;
            hblk_q  <= '0;
            vblk_q  <= '0;
            pat_q   <= '0;
            col_q   <= '0;
            fcnt_q  <= '0;
            hs_q    <= 1'b0;
            vs_q    <= 1'b0;
            de_q    <= 1'b0;
            fs_q    <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            v_q     <= v_d;
            hb_q    <= hb_d;
            vb_q    <= vb_d;
            hblk_q  <= hblk_d;
            vblk_q  <= vblk_d;
            pat_q   <= pat_d;
            col_q   <= col_d;
            fcnt_q  <= fcnt_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            de_q    <= de_d;
            fs_q    <= fs_d;
            data_q  <= data_d;
        end
    end

    assign vid.hs_o          = hs_q;
    assign vid.vs_o          = vs_q;
    assign vid.de_o          = de_q;
    assign vid.data_o        = data_q;
    assign vid.frame_start_o = fs_q;
    assign vid.frame_cnt_o   = fcnt_q;

endmodule

// File: tb/tb_vid_timing_gen.sv
// Scoreboard bench for vid_timing_gen: a raster model indexed by linear pixel
// position predicts every output cycle; a monitor pops and compares.
module tb_vid_timing_gen;

    localparam int HW = 8, HS = 10, HSY = 2, HT = 14;
    localparam int VH = 4, VS = 5, VSY = 1, VT = 7;
    localparam int KH = 3, KV = 2;
    localparam int FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        en_i;
    logic [1:0]  pattern_i;
    logic [23:0] color_i;

    always #5 clk = ~clk;

    vid_timing_gen_if vif ();

    vid_timing_gen #(
        .H_WIDTH (HW), .H_START (HS), .H_SYNC (HSY), .H_TOTAL (HT),
        .V_HEIGHT(VH), .V_START (VS), .V_SYNC (VSY), .V_TOTAL (VT),
        .KH      (KH), .KV      (KV)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .en_i      (en_i),
        .pattern_i (pattern_i),
        .color_i   (color_i),
        .vid       (vif)
    );

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic        fs;
        logic [23:0] data;
        logic [7:0]  fcnt;
    } out_t;

    typedef struct {
        out_t o;
        int   idx;
    } exp_t;

    exp_t sb_q[$];
    int   fs_seen[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   step_idx = 0;
    int   de_first = -1;
    bit   de_armed = 1'b0;

    // Reference model state: running flag and linear position within the frame
    bit          m_run  = 1'b0;
    int          m_p    = 0;
    int          m_fcnt = 0;
    int          m_pat  = 0;
    logic [23:0] m_col  = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic out_t model_out();
        out_t        o;
        int          h, v;
        logic [23:0] chk_px;
        o = '0;
        if (m_run) begin
            h    = m_p % HT;
            v    = m_p / HT;
            o.de = (h < HW) && (v < VH);
            o.hs = (h >= HS) && (h < HS + HSY);
            o.vs = (v >= VS) && (v < VS + VSY);
            o.fs = (m_p == 0);
            chk_px = (((h / KH) + (v / KV)) % 2 == 0) ? 24'hFFFFFF : 24'h000000;
            if (o.de) begin
                case (m_pat)
                    0:       o.data = m_col;
                    1:       o.data = chk_px;
                    2:       o.data = {3{8'(h)}};
                    default: o.data = (m_fcnt % 2 == 1) ? ~chk_px : chk_px;
                endcase
            end
        end
        return o;
    endfunction

    // Drive one cycle of inputs and push the output expected after its clock edge
    task automatic step(input bit r, input bit e, input logic [1:0] pt, input logic [23:0] c);
        exp_t x;
        @(negedge clk);
        rst_i     = r;
        en_i      = e;
        pattern_i = pt;
        color_i   = c;
        if (r) begin
            m_run  = 1'b0;
            m_p    = 0;
            m_fcnt = 0;
            x.o    = '0;
        end else begin
            x.o = model_out();
            if (!m_run) begin
                if (e) begin
                    m_run = 1'b1;
                    m_p   = 0;
                    m_pat = int'(pt);
                    m_col = c;
                end
            end else if (m_p == FRAME - 1) begin
                m_fcnt = (m_fcnt + 1) % 256;
                m_p    = 0;
                if (e) begin
                    m_pat = int'(pt);
                    m_col = c;
                end else begin
                    m_run = 1'b0;
                end
            end else begin
                m_p++;
            end
            x.o.fcnt = 8'(m_fcnt);
        end
        x.idx = step_idx;
        sb_q.push_back(x);
        step_idx++;
    endtask

    task automatic drain();
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk) begin
        exp_t e;
        out_t a;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            a = {vif.hs_o, vif.vs_o, vif.de_o, vif.frame_start_o, vif.data_o, vif.frame_cnt_o};
            chk($sformatf("pixel@%0d", e.idx), 64'(a), 64'(e.o));
            if (a.fs) fs_seen.push_back(e.idx);
            if (de_armed && a.de && de_first < 0) de_first = e.idx;
        end
    end

    initial begin
        int s0, s1, guard, fs_before;
        int exp_fs[3];
        exp_fs[0] = 2;
        exp_fs[1] = 2 + FRAME;
        exp_fs[2] = 2 + 2 * FRAME;
        rst_i = 1'b1; en_i = 1'b0; pattern_i = '0; color_i = '0;
        repeat (3) step(1'b1, 1'b0, 2'd0, 24'h0);

        // Start from reset, checkerboard; frame starts at cycles 2, 100, 198
        s0 = step_idx;
        fs_seen.delete();
        de_first = -1;
        de_armed = 1'b1;
        repeat (210) step(1'b0, 1'b1, 2'd1, 24'($urandom));
        drain();
        chk("first_de_cycle", 64'(de_first - s0 + 1), 64'(2));
        if (fs_seen.size() < 3) begin
            chk("frame_start_count", 64'(fs_seen.size()), 64'(3));
        end else begin
            for (int i = 0; i < 3; i++)
                chk($sformatf("frame_start_cycle%0d", i), 64'(fs_seen[i] - s0 + 1), 64'(exp_fs[i]));
        end

        // Random pattern/colour changes every cycle; only frame-start values matter
        repeat (4 * FRAME) step(1'b0, 1'b1, 2'($urandom_range(0, 3)), 24'($urandom));

        // Drop en mid-frame: frame completes, no further frame starts
        guard = 0;
        while (!(m_run && m_p == 3 * HT) && guard < 2 * FRAME) begin
            step(1'b0, 1'b1, 2'($urandom_range(0, 3)), 24'($urandom));
            guard++;
        end
        chk("reach_mid_frame", 64'(guard < 2 * FRAME), 64'(1));
        drain();
        fs_before = fs_seen.size();
        repeat (2 * FRAME) step(1'b0, 1'b0, 2'($urandom_range(0, 3)), 24'($urandom));
        drain();
        chk("no_frame_start_after_drop", 64'(fs_seen.size()), 64'(fs_before));

        // Reset at h=5, v=2 then restart with en held high
        guard = 0;
        while (!(m_run && m_p == 2 * HT + 5) && guard < 3 * FRAME) begin
            step(1'b0, 1'b1, 2'($urandom_range(0, 3)), 24'($urandom));
            guard++;
        end
        chk("reach_h5_v2", 64'(guard < 3 * FRAME), 64'(1));
        step(1'b1, 1'b1, 2'd2, 24'h0);
        s1 = step_idx;
        drain();
        de_first = -1;
        repeat (40) step(1'b0, 1'b1, 2'd2, 24'h0);
        drain();
        chk("restart_first_de_cycle", 64'(de_first - s1 + 1), 64'(2));

        // Long random run with occasional reset and en toggles
        repeat (3000) begin
            step(($urandom_range(0, 499) == 0), ($urandom_range(0, 7) != 0),
                 2'($urandom_range(0, 3)), 24'($urandom));
        end
        drain();
        chk("scoreboard_drained", 64'(sb_q.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
